// File: rtl/frame_strobe_writer_if.sv
// Configuration word stream between the bitstream loader (master) and the frame writer (slave).
interface frame_strobe_writer_if #(
  parameter int unsigned DataW = 32
) ();
  logic [DataW-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_strobe_writer.sv
// Assembles NumRows configuration words into FrameData, then fires one registered strobe bit
// selected by the header's column/frame fields, followed by a one-cycle data hold.
module frame_strobe_writer #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned NumColumns      = 2,
  parameter logic [7:0]  SyncByte        = 8'hFA
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  frame_strobe_writer_if.slave                  bus,
  output logic [NumRows*FrameBitsPerRow-1:0]    o_frame_data,
  output logic [NumColumns*MaxFramesPerCol-1:0] o_frame_strobe,
  output logic                                  o_busy,
  output logic                                  o_hdr_err,
  output logic [15:0]                           o_frame_count
);

  localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned ColW    = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int unsigned StrobeW = NumColumns * MaxFramesPerCol;
  localparam int unsigned DataW   = NumRows * FrameBitsPerRow;

  typedef enum logic [1:0] {StIdle, StLoad, StStrobe, StHold} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [RowW-1:0]     r_row_cnt;
  logic [ColW-1:0]     r_col;
  logic [4:0]          r_frame;
  logic [DataW-1:0]    r_frame_data;
  logic [StrobeW-1:0]  r_strobe;
  logic [StrobeW-1:0]  w_strobe_d;
  logic                r_hdr_err;
  logic [15:0]         r_frame_count;

  logic                w_ready;
  logic                w_xfer;
  logic [7:0]          w_hdr_sync;
  logic [7:0]          w_hdr_col;
  logic [4:0]          w_hdr_frame;
  logic                w_hdr_ok;
  logic                w_last_row;
  logic                w_unused_hdr;
  int unsigned         w_strobe_idx;

  assign w_ready      = (r_state == StIdle) || (r_state == StLoad);
  assign w_xfer       = bus.s_valid && w_ready;
  assign w_hdr_sync   = bus.s_data[31:24];
  assign w_hdr_col    = bus.s_data[23:16];
  assign w_hdr_frame  = bus.s_data[4:0];
  assign w_unused_hdr = ^bus.s_data[15:5];
  assign w_hdr_ok     = (w_hdr_sync == SyncByte) && (32'(w_hdr_col) < NumColumns) &&
                        (32'(w_hdr_frame) < MaxFramesPerCol);
  assign w_last_row   = (r_row_cnt == RowW'(NumRows - 1));
  assign w_strobe_idx = 32'(r_col) * MaxFramesPerCol + 32'(r_frame);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_xfer && w_hdr_ok) w_state_d = StLoad;
      StLoad:   if (w_xfer && w_last_row) w_state_d = StStrobe;
      StStrobe: w_state_d = StHold;
      StHold:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Strobe is computed one cycle ahead so the output comes straight from a flop.
  always_comb begin
    w_strobe_d = '0;
    if (w_state_d == StStrobe) begin
      w_strobe_d = StrobeW'(1) << w_strobe_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_cnt     <= '0;
      r_col         <= '0;
      r_frame       <= '0;
      r_frame_data  <= '0;
      r_strobe      <= '0;
      r_hdr_err     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hdr_err <= (r_state == StIdle) && w_xfer && !w_hdr_ok;
      r_strobe  <= w_strobe_d;
      if (r_state == StStrobe) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if ((r_state == StIdle) && w_xfer && w_hdr_ok) begin
        r_col     <= w_hdr_col[ColW-1:0];
        r_frame   <= w_hdr_frame;
        r_row_cnt <= '0;
      end
      if ((r_state == StLoad) && w_xfer) begin
        r_frame_data[r_row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= bus.s_data;
        r_row_cnt <= r_row_cnt + RowW'(1);
      end
    end
  end

  assign bus.s_ready    = w_ready;
  assign o_frame_data   = r_frame_data;
  assign o_frame_strobe = r_strobe;
  assign o_busy         = (r_state != StIdle);
  assign o_hdr_err      = r_hdr_err;
  assign o_frame_count  = r_frame_count;

endmodule

// File: doc/frame_strobe_writer.md
Name: frame_strobe_writer

Overview:
- Producer side of the configuration frame interface: drives FrameData and one-hot FrameStrobe pulses into the tile columns, which buffer and forward them.
- Accepts a 32-bit configuration word stream with a valid/ready handshake.
- Assembles one frame (NumRows words) and pulses exactly one strobe bit per frame.
- Sits between the bitstream loader and the fabric's column strobe inputs.

Parameters:
- MaxFramesPerCol, 20, frames per column (strobe bits per column)
- FrameBitsPerRow, 32, data bits per row per frame (equals word width)
- NumRows, 4, tile rows fed by FrameData
- NumColumns, 2, columns addressed; FrameStrobe is NumColumns*MaxFramesPerCol wide
- SyncByte, 8'hFA, required value of header bits [31:24]

Ports:
- CLK  input  1  configuration clock, rising edge
- resetn  input  1  asynchronous active-low reset
- s_data  input  32  configuration word
- s_valid  input  1  s_data valid
- s_ready  output  1  writer accepts s_data this cycle
- FrameData  output  NumRows*FrameBitsPerRow  frame contents; row r occupies bits [r*32+:32]
- FrameStrobe  output  NumColumns*MaxFramesPerCol  one-hot strobe; bit = col*MaxFramesPerCol+frame
- busy  output  1  high whenever state != IDLE
- hdr_err  output  1  one-cycle pulse when a header is rejected
- frame_count  output  16  frames written since reset; wraps 16'hFFFF->0

Behaviour:
- Handshake: a word transfers on a rising edge where s_valid && s_ready. s_ready is combinational from state only: 1 in IDLE and LOAD, 0 in STROBE and HOLD. It never depends on s_valid.
- Header format:
  - [31:24] must equal SyncByte.
  - [23:16] = column index.
  - [4:0] = frame index.
  - Other bits are ignored.
- States and transitions:
  - IDLE: waits for a header transfer.
    - Valid header (sync matches, col < NumColumns, frame < MaxFramesPerCol): latch col and frame, clear row counter, go to LOAD.
    - Invalid header: pulse hdr_err for 1 cycle and stay in IDLE. The word is consumed and no state is changed.
  - LOAD: each transfer writes FrameData row[row_cnt] and increments row_cnt.
    - On the transfer where row_cnt == NumRows-1, go to STROBE.
    - Words arrive in row order 0..NumRows-1.
    - Gaps (s_valid low) are allowed with no timeout.
  - STROBE (1 cycle): FrameStrobe[col*MaxFramesPerCol+frame] = 1, all other bits 0. frame_count increments at the end of this cycle. Next state is HOLD.
  - HOLD (1 cycle): FrameStrobe all 0; FrameData unchanged (hold time for tile latches). Next state is IDLE.
- Timing: if the last data word transfers at edge M, the strobe is high in cycle M+1, s_ready is low in cycles M+1 and M+2, and s_ready returns high in cycle M+3.
- FrameData changes only on LOAD transfers. It is held between frames and is never cleared except by reset.
- FrameStrobe is registered, glitch-free, and at most one bit is ever high.
- Reset (resetn low, asynchronous): state=IDLE, FrameData=0, FrameStrobe=0, hdr_err=0, frame_count=0, row_cnt=0, busy=0.
  - Reset during LOAD or STROBE abandons the frame: no strobe fires after reset, and a strobe already high drops immediately.
  - Deassertion is synchronised externally.
- Every header in IDLE is checked for sync; there is no resynchronisation search inside LOAD.
- Width rule: row_cnt is $clog2(NumRows) bits, with a minimum of 1.

Test Plan:
- Reset values: assert resetn=0 mid-stream -> all outputs 0 at once. After release, s_ready=1 and busy=0.
- Basic frame: header 32'hFA01_0007, then words 11111111/22222222/33333333/44444444 with s_valid held high.
  - FrameData = 128'h44444444_33333333_22222222_11111111.
  - FrameStrobe bit 27 high for exactly 1 cycle, one cycle after the last word.
  - s_ready low for 2 cycles; frame_count=1.
- Bad headers:
  - 32'hFB00_0000 (bad sync) -> hdr_err single pulse, state stays IDLE.
  - 32'hFA02_0000 (col=2) -> hdr_err pulse, state stays IDLE.
  - 32'hFA00_0014 (frame=20) -> hdr_err pulse, state stays IDLE.
  - In all three cases FrameStrobe stays 0 and the next valid header is accepted normally.
- Gapped load: toggle s_valid randomly during 4 data words -> rows are written in order, the strobe fires only after the 4th transfer, and FrameData is unchanged by non-transfer cycles.
- Reset mid-operation:
  - resetn pulsed low after 2 data words -> no strobe, FrameData=0.
  - resetn pulsed low during STROBE -> the strobe drops asynchronously and frame_count stays at its pre-frame value.
- Back-to-back frames: a header is presented during HOLD with s_valid=1 -> it is not accepted until the IDLE cycle.
  - The two strobes are separated by at least 2+NumRows cycles.
  - frame_count=2.
  - Scoreboard checks one-hot FrameStrobe on every cycle.
